shift_cmd_queue: RTL and testbench

SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

---
 rtl/shift_cmd_queue.sv | 130 +++++++++++++
 tb/tb_shift_cmd_queue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_queue.sv
// Purpose: queues rotate commands and sequences them through an external registered barrel shifter.
// Latency: a command accepted into an empty, idle queue in cycle N gives sh_load in N+2 and res_valid in N+4.
// Backpressure: cmd_ready drops when DEPTH entries are queued; a result is held in HOLD until res_ready.
//
// Ports:
//   CK, RS                      clock, synchronous active-low reset
//   cmd_valid/ready/data/amt/dir  upstream command handshake and payload
//   sh_in/sh_by/sh_l_r/sh_load  drive to the shifter; sh_out is its registered result
//   res_valid/ready/data        downstream result handshake
//   level                       current FIFO occupancy
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     CK,
  input  logic                     RS,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [2:0]               cmd_amt,
  input  logic                     cmd_dir,
  output logic [WIDTH-1:0]         sh_in,
  output logic [2:0]               sh_by,
  output logic                     sh_l_r,
  output logic                     sh_load,
  input  logic [WIDTH-1:0]         sh_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       amt;
    logic             dir;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  cmd_t            cmd_in;
  cmd_t            head;
  logic            push;
  logic            pop;
  logic            start_issue;

  assign cmd_in    = '{data: cmd_data, amt: cmd_amt, dir: cmd_dir};
  // Full flag comes from registered occupancy only, never from cmd_valid.
  assign cmd_ready = (level != LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // The head entry leaves the FIFO at the end of the ISSUE cycle.
  assign pop       = (state == ISSUE);

  // An empty FIFO can only be entering ISSUE because of a same-cycle push
  // out of HOLD; that entry is not in memory yet, so forward it directly.
  assign head = (level == '0) ? cmd_in : mem[rd_ptr];

  // Shifter operands are registered, so the decision to enter ISSUE is made
  // one cycle early and loads sh_* together with the state change.
  assign start_issue = ((state == IDLE) && (level != '0)) ||
                       ((state == HOLD) && res_ready && ((level != '0) || push));

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge CK) begin
    if (RS && push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge CK) begin
    if (!RS) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      sh_load   <= 1'b0;
      sh_in     <= '0;
      sh_by     <= '0;
      sh_l_r    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);

      sh_load <= start_issue;
      if (start_issue) begin
        sh_in  <= head.data;
        sh_by  <= head.amt;
        sh_l_r <= head.dir;
      end

      case (state)
        IDLE: begin
          if (start_issue) state <= ISSUE;
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // sh_out reflects the load issued in the previous cycle.
          res_data  <= sh_out;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= start_issue ? ISSUE : IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: models the external registered barrel shifter,
// keeps a scoreboard of golden rotate results in acceptance order, and runs
// one task per scenario.
module tb_shift_cmd_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic                   CK = 1'b0;
  logic                   RS;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [WIDTH-1:0]       cmd_data;
  logic [2:0]             cmd_amt;
  logic                   cmd_dir;
  logic [WIDTH-1:0]       sh_in;
  logic [2:0]             sh_by;
  logic                   sh_l_r;
  logic                   sh_load;
  logic [WIDTH-1:0]       sh_out = '0;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH-1:0]       res_data;
  logic [$clog2(DEPTH):0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_results = 0;

  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  logic       prev_load = 1'b0;

  shift_cmd_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CK(CK), .RS(RS),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_amt(cmd_amt), .cmd_dir(cmd_dir),
    .sh_in(sh_in), .sh_by(sh_by), .sh_l_r(sh_l_r), .sh_load(sh_load),
    .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .level(level)
  );

  always #5 CK = ~CK;

  function automatic logic [7:0] rot(input logic [7:0] d, input logic [2:0] a, input logic r);
    logic [15:0] t;
    t = {d, d};
    if (r) begin
      t = t >> a;
      return t[7:0];
    end
    t = t << a;
    return t[15:8];
  endfunction

  // External shifter: registered, updates only on its parallel-load strobe.
  always @(posedge CK) begin
    if (sh_load) sh_out <= rot(sh_in, sh_by, sh_l_r);
  end

  // Scoreboard and strobe monitor, sampled mid-cycle.
  always @(negedge CK) begin
    if (!RS) begin
      exp_q.delete();
      prev_load = 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        n_checks++;
        n_results++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: result %h with nothing outstanding", res_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (res_data !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_data: got %h want %h", res_data, mon_exp);
          end
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(rot(cmd_data, cmd_amt, cmd_dir));
      if (sh_load) begin
        n_checks++;
        if (prev_load) begin
          n_fail++;
          $display("FAIL sh_load_pulse: high 2 cycles, got 1 want 0");
        end
      end
      prev_load = sh_load;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CK);
      if (exp_q.size() == 0 && level == '0 && !res_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: outstanding %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    RS = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h55; cmd_amt = 3'd2; cmd_dir = 1'b0; res_ready = 1'b0;
    tick(); tick();
    @(negedge CK);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (sh_load !== 1'b0) begin n_fail++; $display("FAIL reset_sh_load: got %b want 0", sh_load); end
    n_checks++; if ({sh_in, sh_by, sh_l_r} !== 12'h000) begin n_fail++; $display("FAIL reset_sh_bus: got %h/%0d/%b want 0", sh_in, sh_by, sh_l_r); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_checks++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h want 00", res_data); end
    tick();
    cmd_valid = 1'b0; RS = 1'b1;
    @(negedge CK);
    n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_ignore_valid: level %0d want 0", level); end
    tick();
  endtask

  task automatic test_latency();
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_data = 8'h81; cmd_amt = 3'd1; cmd_dir = 1'b0;
    @(negedge CK);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lat_accept: cmd_ready %b want 1", cmd_ready); end
    tick(); cmd_valid = 1'b0;
    @(negedge CK);
    n_checks++; if (sh_load !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL lat_n1: sh_load %b level %0d want 0/1", sh_load, level); end
    tick(); @(negedge CK);
    n_checks++; if (sh_load !== 1'b1 || sh_in !== 8'h81 || sh_by !== 3'd1 || sh_l_r !== 1'b0) begin
      n_fail++; $display("FAIL lat_n2_issue: load %b in %h by %0d dir %b want 1/81/1/0", sh_load, sh_in, sh_by, sh_l_r);
    end
    tick(); @(negedge CK);
    n_checks++; if (res_valid !== 1'b0 || sh_load !== 1'b0) begin n_fail++; $display("FAIL lat_n3: res_valid %b sh_load %b want 0/0", res_valid, sh_load); end
    tick(); @(negedge CK);
    n_checks++; if (res_valid !== 1'b1 || res_data !== 8'h03) begin n_fail++; $display("FAIL lat_n4: res_valid %b data %h want 1/03", res_valid, res_data); end
    tick();
    drain();
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic [2:0] a, input logic r);
    cmd_valid = 1'b1; cmd_data = d; cmd_amt = a; cmd_dir = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      if (cmd_ready) break;
      tick();
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_result(output logic [7:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      if (res_valid) begin
        d = res_data; ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_rotate();
    logic [7:0] d;
    bit ok;
    res_ready = 1'b1;
    send_cmd(8'h81, 3'd1, 1'b1);
    get_result(d, ok);
    n_checks++; if (!ok || d !== 8'hC0) begin n_fail++; $display("FAIL rot_right: got %h (seen %b) want c0", d, ok); end
    drain();
    send_cmd(8'hA5, 3'd0, 1'b1);
    get_result(d, ok);
    n_checks++; if (!ok || d !== 8'hA5) begin n_fail++; $display("FAIL rot_zero: got %h (seen %b) want a5", d, ok); end
    drain();
  endtask

  task automatic test_backpressure();
    int  k = 0;
    bit  took = 1'b0;
    bit  accepted = 1'b0;
    bit  early = 1'b0;
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_data = 8'h30 + 8'(k * 17); cmd_amt = 3'(k + 2); cmd_dir = k[0];
      @(negedge CK);
      if (cmd_ready) k++;
      tick();
    end
    @(negedge CK);
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", k); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready: got %b want 0", cmd_ready); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", level); end
    tick();
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      if (cmd_ready) begin
        accepted = 1'b1;
        early = !took;
        break;
      end
      if (res_valid && res_ready) took = 1'b1;
      tick();
    end
    n_checks++; if (!accepted || early) begin n_fail++; $display("FAIL bp_sixth: accepted %b before_result %b want 1/0", accepted, early); end
    tick();
    drain();
  endtask

  task automatic test_stream();
    int sent = 0;
    int base = n_results;
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 8'($urandom); cmd_amt = 3'($urandom); cmd_dir = 1'($urandom);
    for (int i = 0; i < 300 && sent < 16; i++) begin
      @(negedge CK);
      if (cmd_ready) sent++;
      tick();
      if (sent > 0 && cmd_ready) begin
        cmd_data = 8'($urandom); cmd_amt = 3'($urandom); cmd_dir = 1'($urandom);
      end
    end
    cmd_valid = 1'b0;
    drain();
    n_checks++; if (n_results - base != 16 || sent != 16) begin n_fail++; $display("FAIL stream_count: results %0d sent %0d want 16/16", n_results - base, sent); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cmd_data = 8'h11 * 8'(i + 1); cmd_amt = 3'(i); cmd_dir = 1'b1;
      @(negedge CK);
      if (!cmd_ready) break;
      tick();
    end
    tick();
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge CK);
    n_checks++; if (res_valid !== 1'b1 || level !== 3'd4) begin n_fail++; $display("FAIL rm_hold: res_valid %b level %0d want 1/4", res_valid, level); end
    tick(); res_ready = 1'b0;
    @(negedge CK);
    n_checks++; if (sh_load !== 1'b1) begin n_fail++; $display("FAIL rm_issue: sh_load %b want 1", sh_load); end
    tick(); RS = 1'b0;
    @(negedge CK);
    n_checks++; if (level !== 3'd3 || sh_load !== 1'b0) begin n_fail++; $display("FAIL rm_capture: level %0d sh_load %b want 3/0", level, sh_load); end
    tick(); RS = 1'b1;
    @(negedge CK);
    n_checks++; if (level !== '0 || res_valid !== 1'b0 || sh_load !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_after: level %0d res_valid %b sh_load %b cmd_ready %b want 0/0/0/1", level, res_valid, sh_load, cmd_ready);
    end
    tick(); @(negedge CK);
    n_checks++; if (res_valid !== 1'b0 || sh_load !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: res_valid %b sh_load %b want 0/0", res_valid, sh_load); end
    tick();
    drain();
  endtask

  task automatic test_push_handshake();
    int base = n_results;
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 8'hC3 ^ 8'(i * 37); cmd_amt = 3'(7 - i); cmd_dir = i[0];
      @(negedge CK);
      tick();
    end
    cmd_data = 8'h5A; cmd_amt = 3'd3; cmd_dir = 1'b0; res_ready = 1'b1;
    @(negedge CK);
    n_checks++; if (res_valid !== 1'b1 || level !== 3'(DEPTH - 1) || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL ph_setup: res_valid %b level %0d cmd_ready %b want 1/%0d/1", res_valid, level, cmd_ready, DEPTH - 1);
    end
    tick(); cmd_valid = 1'b0;
    @(negedge CK);
    n_checks++; if (sh_load !== 1'b1) begin n_fail++; $display("FAIL ph_issue: sh_load %b want 1", sh_load); end
    tick(); @(negedge CK);
    // Push on the handshake plus the following pop net to no change.
    n_checks++; if (level !== 3'(DEPTH - 1)) begin n_fail++; $display("FAIL ph_level: got %0d want %0d", level, DEPTH - 1); end
    tick();
    drain();
    n_checks++; if (n_results - base != 5) begin n_fail++; $display("FAIL ph_count: results %0d want 5", n_results - base); end
  endtask

  initial begin
    RS = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_amt = '0; cmd_dir = 1'b0; res_ready = 1'b0;
    test_reset();
    test_latency();
    test_rotate();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_push_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
